// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of requester handshakes (I-cache fill, D-cache
//               fill/write-through) and main-memory bus for mem_arbiter.
//               master = arbiter side, slave = requesters + memory side.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int WORDS = 8
) ();
  localparam int WIDX = $clog2(WORDS);

  // Requester side
  logic            i_req;
  logic [15:0]     i_addr;
  logic            d_req;
  logic [15:0]     d_addr;
  logic            d_wr;
  logic [15:0]     d_wdata;
  logic            i_gnt;
  logic            d_gnt;
  logic            i_fill_valid;
  logic            d_fill_valid;
  logic [15:0]     fill_data;
  logic [WIDX-1:0] fill_word;
  logic            i_done;
  logic            d_done;
  logic            busy;

  // Memory side
  logic            mem_en;
  logic            mem_wr;
  logic [15:0]     mem_addr;
  logic [15:0]     mem_wdata;
  logic [15:0]     mem_data_out;
  logic            mem_data_valid;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata,
    input  mem_data_out, mem_data_valid,
    output i_gnt, d_gnt, i_fill_valid, d_fill_valid, fill_data, fill_word,
    output i_done, d_done, busy,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_wr, d_wdata,
    output mem_data_out, mem_data_valid,
    input  i_gnt, d_gnt, i_fill_valid, d_fill_valid, fill_data, fill_word,
    input  i_done, d_done, busy,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one pipelined main memory between the I-cache fill
//               path and the D-cache fill/write-through path. Fills issue
//               WORDS back-to-back reads of a 16-byte block and route the
//               returned words (tagged by index) to the owner; D-side
//               write-throughs issue a single write. Completion is decided
//               by counting mem_data_valid pulses, so memory latency
//               (nominally 4 cycles) does not matter to correctness.
// Macro       : RR_ARB_EN - round-robin priority on simultaneous requests
//               (undefined: fixed D-over-I priority).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.master bus
);
  localparam int WIDX = $clog2(WORDS);
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(WORDS - 1);
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            owner;
  logic [WIDX-1:0] issue_cnt;
  logic [WIDX-1:0] recv_cnt;
  logic [15:0]     base;
  logic [3:0]      low;
  logic [15:0]     wdata;
  logic            i_gnt_r;
  logic            d_gnt_r;
  logic            grant;
  logic            grant_d;
  logic            rx_valid;
  logic            rx_last;
`ifdef RR_ARB_EN
  logic            last_owner;
`endif

  // Arbitration: who wins when the arbiter is idle
  always_comb begin
    grant = (state == IDLE) && (bus.i_req || bus.d_req);
`ifdef RR_ARB_EN
    // On contention the requester that did not own the previous grant wins
    grant_d = bus.d_req && (!bus.i_req || (last_owner == OWNER_I));
`else
    grant_d = bus.d_req;
`endif
  end

  // Receive path qualifiers: valids only count while a fill is in flight
  always_comb begin
    rx_valid = bus.mem_data_valid && ((state == ISSUE) || (state == DRAIN));
    rx_last  = rx_valid && (recv_cnt == LAST_WORD);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = (grant_d && bus.d_wr) ? WRITE : ISSUE;
        end
      end
      ISSUE: begin
        if (rx_last) begin
          state_nxt = IDLE;
        end else if (issue_cnt == LAST_WORD) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (rx_last) begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transaction context, counters and registered grant pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWNER_I;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
      low       <= '0;
      wdata     <= '0;
      i_gnt_r   <= 1'b0;
      d_gnt_r   <= 1'b0;
`ifdef RR_ARB_EN
      last_owner <= OWNER_I;
`endif
    end else begin
      i_gnt_r <= 1'b0;
      d_gnt_r <= 1'b0;
      if (grant) begin
        owner   <= grant_d ? OWNER_D : OWNER_I;
        i_gnt_r <= !grant_d;
        d_gnt_r <= grant_d;
        base    <= (grant_d ? bus.d_addr : bus.i_addr) & 16'hFFF0;
        // Low address bits only matter for a single-word write-through
        low     <= grant_d ? bus.d_addr[3:0] : 4'h0;
        if (grant_d && bus.d_wr) begin
          wdata <= bus.d_wdata;
        end
`ifdef RR_ARB_EN
        last_owner <= grant_d ? OWNER_D : OWNER_I;
`endif
      end
      if (state_nxt == IDLE) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (state == ISSUE) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (rx_valid) begin
          recv_cnt <= recv_cnt + 1'b1;
        end
      end
    end
  end

  // Output decode: everything is forced low while idle
  always_comb begin
    bus.busy         = (state != IDLE);
    bus.i_gnt        = i_gnt_r;
    bus.d_gnt        = d_gnt_r;
    bus.mem_en       = (state == ISSUE) || (state == WRITE);
    bus.mem_wr       = (state == WRITE);
    bus.mem_addr     = 16'h0000;
    bus.mem_wdata    = 16'h0000;
    if (state == ISSUE) begin
      bus.mem_addr = base | 16'({issue_cnt, 1'b0});
    end else if (state == WRITE) begin
      bus.mem_addr  = base | {12'h000, low};
      bus.mem_wdata = wdata;
    end
    bus.fill_data    = rx_valid ? bus.mem_data_out : 16'h0000;
    bus.fill_word    = rx_valid ? recv_cnt : '0;
    bus.i_fill_valid = rx_valid && (owner == OWNER_I);
    bus.d_fill_valid = rx_valid && (owner == OWNER_D);
    bus.i_done       = rx_last && (owner == OWNER_I);
    bus.d_done       = (rx_last && (owner == OWNER_D)) || (state == WRITE);
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. A transaction-level model
//               predicts grant order, memory operations and fill words; a
//               behavioural memory returns reads after LATENCY cycles (or
//               with irregular extra gaps); a monitor compares every DUT
//               event against the expectation queues.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
  localparam int WORDS   = 8;
  localparam int LATENCY = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WORDS(WORDS)) bus ();

  mem_arbiter #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  // ---------------- memory model ----------------
  typedef struct { logic [15:0] addr; longint due; } rd_t;
  rd_t    pend[$];
  longint cyc = 0;
  longint last_due = 0;
  bit     irregular = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    longint d;
    longint g;
    if (rst) begin
      pend.delete();
      bus.mem_data_valid <= 1'b0;
      bus.mem_data_out   <= 16'h0000;
    end else begin
      if (bus.mem_en && !bus.mem_wr) begin
        d = cyc + LATENCY;
        if (irregular) begin
          g = last_due + 1 + longint'($urandom_range(0, 3));
          if (g > d) d = g;
        end
        pend.push_back('{bus.mem_addr, d});
        last_due = d;
      end
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        bus.mem_data_valid <= 1'b1;
        bus.mem_data_out   <= mem_fn(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.mem_data_valid <= 1'b0;
        bus.mem_data_out   <= 16'($urandom);
      end
    end
  end

  // ---------------- scoreboard queues ----------------
  typedef struct { bit who; bit gap2; } g_t;
  typedef struct { bit wr; logic [15:0] addr; logic [15:0] wdata; } m_t;
  typedef struct { bit who; int word; logic [15:0] data; bit last; bit nominal; } f_t;
  typedef struct { bit who; logic [15:0] addr; bit wr; logic [15:0] wdata; } t_t;

  g_t gq[$];
  m_t mq[$];
  f_t fq[$];
  bit model_last = 1'b0;   // 0 = I, 1 = D

  function automatic void expect_txn(input t_t t, input bit gap2);
    logic [15:0] a;
    gq.push_back('{t.who, gap2});
    if (t.wr) begin
      mq.push_back('{1'b1, t.addr, t.wdata});
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        a = (t.addr & 16'hFFF0) + 16'(2 * k);
        mq.push_back('{1'b0, a, 16'h0000});
        fq.push_back('{t.who, k, mem_fn(a), k == WORDS - 1, !irregular});
      end
    end
    model_last = t.who;
  endfunction

  // ---------------- monitor ----------------
  longint last_done_cyc = -100;
  longint last_gnt_cyc  = 0;
  bit     chk_idle_next = 0;

  always @(negedge clk) begin
    g_t g;
    m_t m;
    f_t f;
    if (!rst) begin
      if (chk_idle_next) begin
        chk("busy_after_write", bus.busy, 0);
        chk_idle_next = 0;
      end
      if (!bus.busy)
        chk("idle_outputs", {bus.i_gnt, bus.d_gnt, bus.i_fill_valid, bus.d_fill_valid,
            bus.fill_data, bus.fill_word, bus.i_done, bus.d_done, bus.mem_en,
            bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
      if (bus.i_gnt || bus.d_gnt) begin
        if (gq.size() == 0) chk("spurious_gnt", {bus.d_gnt, bus.i_gnt}, 0);
        else begin
          g = gq.pop_front();
          chk("gnt_who", {bus.d_gnt, bus.i_gnt}, g.who ? 2'b10 : 2'b01);
          if (g.gap2) chk("gnt_gap_after_done", cyc - last_done_cyc, 2);
          last_gnt_cyc = cyc;
        end
      end
      if (bus.mem_en) begin
        if (mq.size() == 0) chk("spurious_mem_op", bus.mem_addr, 16'hFFFF ^ bus.mem_addr);
        else begin
          m = mq.pop_front();
          chk("mem_wr", bus.mem_wr, m.wr);
          chk("mem_addr", bus.mem_addr, m.addr);
          if (m.wr) begin
            chk("mem_wdata", bus.mem_wdata, m.wdata);
            chk("write_done", {bus.d_done, bus.i_done}, 2'b10);
            chk_idle_next = 1;
            last_done_cyc = cyc;
          end
        end
      end
      if (bus.i_fill_valid || bus.d_fill_valid) begin
        if (fq.size() == 0) chk("spurious_fill", {bus.d_fill_valid, bus.i_fill_valid}, 0);
        else begin
          f = fq.pop_front();
          chk("fill_owner", {bus.d_fill_valid, bus.i_fill_valid}, f.who ? 2'b10 : 2'b01);
          chk("fill_word", bus.fill_word, f.word);
          chk("fill_data", bus.fill_data, f.data);
          chk("fill_done", {bus.d_done, bus.i_done},
              f.last ? (f.who ? 2'b10 : 2'b01) : 2'b00);
          if (f.last) begin
            if (f.nominal) chk("fill_latency", cyc - last_gnt_cyc, WORDS + LATENCY - 1);
            last_done_cyc = cyc;
          end
        end
      end else if ((bus.i_done || bus.d_done) && !(bus.mem_en && bus.mem_wr)) begin
        chk("spurious_done", {bus.d_done, bus.i_done}, 0);
      end
    end
  end

  // ---------------- requester agents ----------------
  task automatic agent(input bit who, input int n_done);
    int seen = 0;
    for (int c = 0; c < 400 && seen < n_done; c++) begin
      @(negedge clk);
      if (who ? bus.d_done : bus.i_done) seen++;
    end
    if (seen < n_done) chk(who ? "d_done_timeout" : "i_done_timeout", seen, n_done);
    if (who) bus.d_req = 1'b0;
    else     bus.i_req = 1'b0;
  endtask

  task automatic run(input bit use_i, input t_t ti, input bit use_d, input t_t td, input bit hold);
    bit d_first;
    @(posedge clk);
    #1;
    if (use_i && use_d) begin
`ifdef RR_ARB_EN
      d_first = (model_last == 1'b0);
`else
      d_first = 1'b1;
`endif
      if (d_first) begin expect_txn(td, 0); expect_txn(ti, 1); end
      else         begin expect_txn(ti, 0); expect_txn(td, 1); end
    end else if (use_i) begin
      expect_txn(ti, 0);
      if (hold) expect_txn(ti, 1);
    end else begin
      expect_txn(td, 0);
      if (hold) expect_txn(td, 1);
    end
    bus.i_addr  = ti.addr;
    bus.d_addr  = td.addr;
    bus.d_wr    = td.wr;
    bus.d_wdata = td.wdata;
    bus.i_req   = use_i;
    bus.d_req   = use_d;
    fork
      if (use_i) agent(1'b0, hold ? 2 : 1);
      if (use_d) agent(1'b1, hold ? 2 : 1);
    join
    repeat (3) @(negedge clk);
    chk("queues_drained", gq.size() + mq.size() + fq.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  t_t ti;
  t_t td;
  int done_seen;

  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0;
    bus.d_wr = 0;  bus.d_wdata = 0;
    #1;
    chk("reset_outputs", {bus.busy, bus.i_gnt, bus.d_gnt, bus.mem_en, bus.i_done, bus.d_done,
        bus.i_fill_valid, bus.d_fill_valid}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);

    // Basic I fill
    ti = '{1'b0, 16'h1236, 1'b0, 16'h0};
    td = '{1'b1, 16'h0000, 1'b0, 16'h0};
    run(1, ti, 0, td, 0);

    // Simultaneous I and D fill
    ti = '{1'b0, 16'h2468, 1'b0, 16'h0};
    td = '{1'b1, 16'h0040, 1'b0, 16'h0};
    run(1, ti, 1, td, 0);

    // D write-through
    td = '{1'b1, 16'h0102, 1'b1, 16'hBEEF};
    run(0, ti, 1, td, 0);

    // Contention after a D grant
    ti = '{1'b0, 16'h3330, 1'b0, 16'h0};
    td = '{1'b1, 16'h4448, 1'b0, 16'h0};
    run(1, ti, 1, td, 0);

    // Irregular memory return spacing
    irregular = 1;
    ti = '{1'b0, 16'h7770, 1'b0, 16'h0};
    run(1, ti, 0, td, 0);
    td = '{1'b1, 16'hABC4, 1'b0, 16'h0};
    run(0, ti, 1, td, 0);
    run(1, ti, 1, td, 0);
    irregular = 0;

    // Reset during the 5th ISSUE cycle
    @(posedge clk);
    #1;
    ti = '{1'b0, 16'h3456, 1'b0, 16'h0};
    expect_txn(ti, 0);
    bus.i_addr = ti.addr;
    bus.i_req  = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20 && !bus.i_gnt; c++) @(negedge clk);
    chk("rst_test_gnt", bus.i_gnt, 1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.i_req = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_outputs", {bus.i_gnt, bus.d_gnt, bus.i_fill_valid, bus.d_fill_valid,
        bus.fill_data, bus.fill_word, bus.i_done, bus.d_done, bus.mem_en,
        bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
    gq.delete(); mq.delete(); fq.delete();
    model_last = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.i_done || bus.d_done) done_seen++;
    end
    chk("no_done_after_rst", done_seen, 0);

    // Fresh fill after reset
    ti = '{1'b0, 16'h1236, 1'b0, 16'h0};
    run(1, ti, 0, td, 0);

    // Request held one cycle past done: re-granted
    ti = '{1'b0, 16'h5550, 1'b0, 16'h0};
    run(1, ti, 0, td, 1);
    td = '{1'b1, 16'h0A0E, 1'b1, 16'h1234};
    run(0, ti, 1, td, 1);

    // Randomized mix
    for (int n = 0; n < 14; n++) begin
      bit ui;
      bit ud;
      irregular = 1'($urandom_range(0, 1));
      ti = '{1'b0, 16'($urandom), 1'b0, 16'h0};
      td = '{1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom)};
      ui = 1'($urandom_range(0, 1));
      ud = 1'($urandom_range(0, 1));
      if (!ui && !ud) ui = 1'b1;
      run(ui, ti, ud, td, 0);
    end
    irregular = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
